dispatch_buffer: RTL

Single-entry, two-lane dispatch stage between rename (R) and the issue queues (P stage).
- Captures the 2-wide renamed bundle from R over a handshake.
- Routes each valid lane, in program order, to the ALU, MDU or LSU issue queue.
- Writes the ROB entry of every dispatched lane.
- Snoops the CDB while instructions wait, so stalled operands are not lost. It owns no ROB counting; R has already guaranteed ROB space.

---
 rtl/dispatch_buffer_if.sv | 44 ++++
 rtl/dispatch_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dispatch_buffer_if.sv
// -----------------------------------------------------------------------------
// dispatch_pkg / handshake_if
//
// Purpose : Shared types for the rename -> dispatch boundary, and the
//           valid/ready handshake interface that carries the renamed bundle.
//
// dispatch_pkg
//   RobWidth    : width of ROB ids / physical tags carried in the bundle.
//   r_p_pkg_t   : 2-wide renamed bundle (lane i owns sources 2i and 2i+1).
//
// handshake_if (modports sender / receiver)
//   valid : bundle on `data` is offered this cycle   (sender -> receiver)
//   ready : receiver accepts the offered bundle      (receiver -> sender)
//   data  : r_p_pkg_t payload                        (sender -> receiver)
// -----------------------------------------------------------------------------

package dispatch_pkg;

   parameter int unsigned RobWidth = 6;

   typedef struct packed {
      logic [1:0]               r_valid;     // lane holds a real instruction
      logic [1:0][RobWidth-1:0] preg;        // destination tag == ROB entry
      logic [3:0][RobWidth-1:0] src_preg;    // producer tag per source
      logic [3:0][31:0]         arf_data;    // operand value per source
      logic [3:0]               data_valid;  // operand value already present
      logic [1:0][2:0]          lsu_type;    // non-zero: memory op
      logic [1:0][2:0]          mdu_type;    // non-zero: mul/div op
      logic [1:0][3:0]          br_type;     // branch kind, carried through
      logic [1:0]               exc_valid;   // lane carries an exception
   } r_p_pkg_t;

endpackage

interface handshake_if;

   logic                   valid;
   logic                   ready;
   dispatch_pkg::r_p_pkg_t data;

   modport sender   (output valid, output data, input ready);
   modport receiver (input valid, input data, output ready);

endinterface

// File: rtl/dispatch_buffer.sv
// -----------------------------------------------------------------------------
// dispatch_buffer
//
// Purpose : Single-entry, two-lane dispatch stage between rename and the
//           issue queues. A bundle captured from rename is held until each
//           valid lane has been written, in program order, into its ALU, MDU
//           or LSU issue queue. Every dispatched lane also writes its ROB
//           entry. While a bundle waits, the CDB is snooped so that results
//           broadcast for still-missing operands are folded into the buffer.
//
// Parameters
//   ROB_WIDTH   : ROB id / physical tag width (must equal dispatch_pkg::RobWidth)
//   CDB_PORTS   : number of writeback broadcast ports
//
// Ports
//   clk            : clock, all state on posedge
//   rst_n          : asynchronous active-low reset
//   r_p_receiver   : bundle handshake from rename
//   c_flush_i      : pipeline flush from commit
//   cdb_valid_i    : per-port broadcast valid
//   cdb_robid_i    : per-port producer tag
//   cdb_data_i     : per-port result value
//   alu/mdu/lsu_ready_i : queue can take two entries this cycle
//   alu/mdu/lsu_valid_o : per-lane write enable into each queue
//   disp_pkg_o     : buffered bundle with CDB-updated operands
//   rob_we_o       : per-lane ROB write; entry index is disp_pkg_o.preg[i]
// -----------------------------------------------------------------------------

module dispatch_buffer
   import dispatch_pkg::*;
#(
   parameter int unsigned ROB_WIDTH = RobWidth,
   parameter int unsigned CDB_PORTS = 2
) (
   input  logic                                clk,
   input  logic                                rst_n,

   handshake_if.receiver                       r_p_receiver,

   input  logic                                c_flush_i,

   input  logic [CDB_PORTS-1:0]                cdb_valid_i,
   input  logic [CDB_PORTS-1:0][ROB_WIDTH-1:0] cdb_robid_i,
   input  logic [CDB_PORTS-1:0][31:0]          cdb_data_i,

   input  logic                                alu_ready_i,
   input  logic                                mdu_ready_i,
   input  logic                                lsu_ready_i,

   output logic [1:0]                          alu_valid_o,
   output logic [1:0]                          mdu_valid_o,
   output logic [1:0]                          lsu_valid_o,
   output r_p_pkg_t                            disp_pkg_o,
   output logic [1:0]                          rob_we_o
);

   typedef enum logic [1:0] {
      ClsAlu = 2'd0,
      ClsMdu = 2'd1,
      ClsLsu = 2'd2
   } cls_e;

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------

   // Fold CDB broadcasts into every still-missing source of a bundle.
   // Ports are scanned from 0 upward and the first hit sticks, so the lowest
   // matching port wins when several broadcast the same tag.
   function automatic r_p_pkg_t f_wakeup(
      input r_p_pkg_t                            pkg,
      input logic [CDB_PORTS-1:0]                v,
      input logic [CDB_PORTS-1:0][ROB_WIDTH-1:0] id,
      input logic [CDB_PORTS-1:0][31:0]          d
   );
      r_p_pkg_t res;
      logic     hit;
      res = pkg;
      for (int j = 0; j < 4; j++) begin
         hit = 1'b0;
         for (int p = 0; p < CDB_PORTS; p++) begin
            if (!hit && !pkg.data_valid[j] && v[p] && (id[p] == pkg.src_preg[j])) begin
               hit               = 1'b1;
               res.data_valid[j] = 1'b1;
               res.arf_data[j]   = d[p];
            end
         end
      end
      return res;
   endfunction

   // Memory ops take priority over mul/div; everything else (branch, CSR,
   // priv, exception-carrying, decode-error) goes to the ALU queue.
   function automatic cls_e f_class(input logic [2:0] lsu_type, input logic [2:0] mdu_type);
      cls_e cls;
      if (lsu_type != 3'd0) begin
         cls = ClsLsu;
      end else if (mdu_type != 3'd0) begin
         cls = ClsMdu;
      end else begin
         cls = ClsAlu;
      end
      return cls;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------

   r_p_pkg_t   r_buf;
   logic [1:0] r_pend;   // lane i still waiting for its queue; 0 == empty

   // --------------------------------------------------------------------------
   // Combinational datapath
   // --------------------------------------------------------------------------

   r_p_pkg_t   w_buf_wk;      // stored bundle with this cycle's CDB applied
   r_p_pkg_t   w_cap_wk;      // incoming bundle with this cycle's CDB applied
   cls_e [1:0] w_cls;
   logic [1:0] w_lane_rdy;    // target queue of lane i can accept
   logic [1:0] w_go;
   logic [1:0] w_pend_drain;  // pending lanes left if nothing is captured
   logic       w_ready;
   logic       w_accept;

   always_comb begin
      w_buf_wk = f_wakeup(r_buf, cdb_valid_i, cdb_robid_i, cdb_data_i);
      w_cap_wk = f_wakeup(r_p_receiver.data, cdb_valid_i, cdb_robid_i, cdb_data_i);
   end

   always_comb begin
      w_lane_rdy = '0;
      for (int i = 0; i < 2; i++) begin
         w_cls[i] = f_class(r_buf.lsu_type[i], r_buf.mdu_type[i]);
         case (w_cls[i])
            ClsLsu:  w_lane_rdy[i] = lsu_ready_i;
            ClsMdu:  w_lane_rdy[i] = mdu_ready_i;
            default: w_lane_rdy[i] = alu_ready_i;
         endcase
      end
   end

   // Lane 1 may only leave once lane 0 is gone or leaves in the same cycle.
   always_comb begin
      w_go[0] = r_pend[0] & w_lane_rdy[0] & ~c_flush_i;
      w_go[1] = r_pend[1] & w_lane_rdy[1] & (~r_pend[0] | w_go[0]) & ~c_flush_i;
   end

   always_comb begin
      w_pend_drain = r_pend & ~w_go;
      // Accept only when the entry is empty or fully drains this cycle.
      w_ready      = ~c_flush_i & (w_pend_drain == 2'b00);
      w_accept     = r_p_receiver.valid & w_ready;
   end

   // --------------------------------------------------------------------------
   // State update
   // --------------------------------------------------------------------------

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_buf  <= '0;
      end else if (c_flush_i) begin
         // Contents become don't-care once nothing is pending.
         r_pend <= '0;
      end else if (w_accept) begin
         r_pend <= r_p_receiver.data.r_valid;
         r_buf  <= w_cap_wk;
      end else begin
         r_pend <= w_pend_drain;
         r_buf  <= w_buf_wk;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------

   always_comb begin
      alu_valid_o = '0;
      mdu_valid_o = '0;
      lsu_valid_o = '0;
      for (int i = 0; i < 2; i++) begin
         alu_valid_o[i] = w_go[i] & (w_cls[i] == ClsAlu);
         mdu_valid_o[i] = w_go[i] & (w_cls[i] == ClsMdu);
         lsu_valid_o[i] = w_go[i] & (w_cls[i] == ClsLsu);
      end
   end

   always_comb begin
      rob_we_o           = w_go;
      disp_pkg_o         = w_buf_wk;
      r_p_receiver.ready = w_ready;
   end

endmodule
